// File: rtl/mult_iter_pkg.sv
// Shared types and helpers for the iterative multiplier: FSM states,
// signedness codes and the step-counter width calculation.
package mult_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mult_state_e;

    localparam logic [1:0] SS_UU = 2'b00;
    localparam logic [1:0] SS_SU = 2'b01;
    localparam logic [1:0] SS_SS = 2'b11;

    // Width of a counter that walks 0..(xlen/radix_bits)-1; never narrower than one bit.
    function automatic int count_bits(input int xlen, input int radix_bits);
        int steps;
        steps = xlen / radix_bits;
        if (steps <= 1) begin
            return 1;
        end else begin
            return $clog2(steps);
        end
    endfunction

endpackage

// File: rtl/mult_iter_step.sv
// One radix digit of the shift-add multiplier: builds the partial product of the
// (pre-shifted) multiplicand and a RADIX_BITS digit and adds it to the accumulator.
module mult_iter_step #(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 4
) (
    input  logic [2*XLEN-1:0]     acc_i,
    input  logic [2*XLEN-1:0]     mcand_i,
    input  logic [RADIX_BITS-1:0] digit_i,
    output logic [2*XLEN-1:0]     acc_o
);

    logic [2*XLEN-1:0] pp_s;

    // Partial product as a sum of multiplicand copies selected by the digit bits.
    always_comb begin
        pp_s = '0;
        for (int j = 0; j < RADIX_BITS; j++) begin
            if (digit_i[j]) begin
                pp_s = pp_s + (mcand_i << j);
            end else begin
                pp_s = pp_s;
            end
        end
        acc_o = acc_i + pp_s;
    end

endmodule

// File: rtl/mult_iter_unit.sv
// Iterative MUL/MULH/MULHSU/MULHU unit: unsigned magnitude shift-add over
// XLEN/RADIX_BITS cycles, sign fix-up at the end, start/valid handshake.
module mult_iter_unit
    import mult_iter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 4,
    parameter int ZERO_FAST  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable_i,
    input  logic            mul_hi_i,
    input  logic [1:0]      short_signed_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            ex_ready_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int W2    = 2 * XLEN;
    localparam int N     = XLEN / RADIX_BITS;
    localparam int CNT_W = count_bits(XLEN, RADIX_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mult_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [W2-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic            neg_q, neg_d;
    logic            hi_q, hi_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic            zero_s;
    logic [XLEN-1:0] mag_a_s;
    logic [XLEN-1:0] mag_b_s;
    logic [W2-1:0]   step_acc_s;
    logic [W2-1:0]   final_s;

    // Code 2'b10 is not a legal mode; bit 0 alone marks a signed a, and b is
    // signed only for the full signed/signed code, so 2'b10 degrades to unsigned.
    assign a_neg_s  = short_signed_i[0] & op_a_i[XLEN-1];
    assign b_neg_s  = (short_signed_i == SS_SS) & op_b_i[XLEN-1];
    assign mag_a_s  = a_neg_s ? (-op_a_i) : op_a_i;
    assign mag_b_s  = b_neg_s ? (-op_b_i) : op_b_i;
    assign zero_s   = (op_a_i == '0) | (op_b_i == '0);

    assign ready_o  = (state_q == IDLE) | ((state_q == DONE) & ex_ready_i);
    assign accept_s = enable_i & ready_o & ~flush_i;
    assign valid_o  = valid_q;
    assign result_o = result_q;

    mult_iter_step #(
        .XLEN       (XLEN),
        .RADIX_BITS (RADIX_BITS)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .digit_i (mplier_q[RADIX_BITS-1:0]),
        .acc_o   (step_acc_s)
    );

    assign final_s = neg_q ? (-step_acc_s) : step_acc_s;

    // Next-state and datapath control; flush has priority over everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        valid_d  = valid_q;
        result_d = result_q;

        if (flush_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = '0;
            mplier_d = '0;
            neg_d    = 1'b0;
            valid_d  = 1'b0;
        end else if (accept_s) begin
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, mag_a_s};
            mplier_d = mag_b_s;
            neg_d    = a_neg_s ^ b_neg_s;
            hi_d     = mul_hi_i;
            if ((ZERO_FAST != 0) && zero_s) begin
                state_d  = DONE;
                valid_d  = 1'b1;
                result_d = '0;
            end else begin
                state_d  = CALC;
                valid_d  = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                CALC: begin
                    acc_d    = step_acc_s;
                    mcand_d  = mcand_q << RADIX_BITS;
                    mplier_d = mplier_q >> RADIX_BITS;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d    = '0;
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        result_d = hi_q ? final_s[W2-1:XLEN] : final_s[XLEN-1:0];
                    end else begin
                        cnt_d    = cnt_q + CNT_ONE;
                        state_d  = CALC;
                    end
                end
                DONE: begin
                    if (ex_ready_i) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            hi_q     <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

endmodule
